// File: rtl/reg_file_reader.sv
// reg_file_reader
//   Read side of the register bank. Accepts a request naming two register
//   addresses, captures both words on the accepting edge and presents them on a
//   one-entry valid/ready response stage with full throughput.
//
//   A bank write landing on the accepting edge is forwarded, so a read never
//   returns a stale value. Once captured, a response is a snapshot: it does not
//   change while it waits under backpressure, even if the bank rewrites that
//   register.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   regs_flat               bank contents, reg i = regs_flat[i*WIDTH +: WIDTH]
//   wr_en/wr_addr/wr_data   bank write landing on this same clk edge
//   req_valid/req_ready     request handshake (req_ready is combinational)
//   rd_addr_a/rd_addr_b     port addresses, sampled at acceptance
//   rsp_valid/rsp_ready     response handshake
//   rsp_data_a/rsp_data_b   registered port results
//   rd_count                completed responses, wraps 0xFFFF -> 0
module reg_file_reader #(
  parameter int WIDTH    = 32,
  parameter int N_REGS   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REGS*WIDTH-1:0] regs_flat,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       rd_addr_a,
  input  logic [ADDR_W-1:0]       rd_addr_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data_a,
  output logic [WIDTH-1:0]        rsp_data_b,
  output logic [15:0]             rd_count
);

  // Value one port captures: hard-wired zero register, then out-of-range
  // addresses, then same-edge write forwarding, then the bank word.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0]       addr,
    input logic [N_REGS*WIDTH-1:0] regs,
    input logic                    we,
    input logic [ADDR_W-1:0]       wa,
    input logic [WIDTH-1:0]        wd
  );
    logic [WIDTH-1:0] val;
    if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
      val = {WIDTH{1'b0}};
    end else if (32'(addr) >= 32'(N_REGS)) begin
      val = {WIDTH{1'b0}};
    end else if (we && (wa == addr)) begin
      val = wd;
    end else begin
      val = regs[32'(addr)*WIDTH +: WIDTH];
    end
    return val;
  endfunction

  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_a_r;
  logic [WIDTH-1:0] rsp_data_b_r;
  logic [15:0]      rd_count_r;
  logic             req_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] rd_data_a_s;
  logic [WIDTH-1:0] rd_data_b_s;

  // Ready whenever the response slot is empty or is being drained this cycle.
  assign req_ready_s = !rsp_valid_r || rsp_ready;
  assign accept_s    = req_valid && req_ready_s;

  // Candidate capture values for both ports; only used on an accepting edge.
  always_comb begin
    rd_data_a_s = read_port(rd_addr_a, regs_flat, wr_en, wr_addr, wr_data);
    rd_data_b_s = read_port(rd_addr_b, regs_flat, wr_en, wr_addr, wr_data);
  end

  // Response slot, captured data snapshot and completion counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r  <= 1'b0;
      rsp_data_a_r <= {WIDTH{1'b0}};
      rsp_data_b_r <= {WIDTH{1'b0}};
      rd_count_r   <= 16'd0;
    end else begin
      if (accept_s) begin
        rsp_valid_r  <= 1'b1;
        rsp_data_a_r <= rd_data_a_s;
        rsp_data_b_r <= rd_data_b_s;
      end else if (rsp_ready) begin
        // Drained with nothing behind it: data keeps its last value.
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
      if (rsp_valid_r && rsp_ready) begin
        rd_count_r <= rd_count_r + 16'd1;
      end else begin
        rd_count_r <= rd_count_r;
      end
    end
  end

  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data_a = rsp_data_a_r;
  assign rsp_data_b = rsp_data_b_r;
  assign rd_count   = rd_count_r;

endmodule
